serial_bus_arbiter: RTL and testbench

//  Two-master arbiter for the shared serial bus. It sits between master1/master2 and the
//  bus interconnect, and grants exclusive bus ownership for one whole transaction
//  (single or burst). Fair round-robin when both masters request. A watchdog revokes
//  any grant that is held too long, and one turnaround cycle separates owners.

---
 rtl/serial_bus_pkg.sv | 15 +
 rtl/arb_watchdog.sv | 30 +++
 rtl/serial_bus_arbiter.sv | 100 ++++++++++
 tb/tb_serial_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the two-master serial bus arbiter.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M1 = 2'd1,
        GRANT_M2 = 2'd2,
        HANDOVER = 2'd3
    } arb_state_t;

    // bus_owner / last_owner encoding: mux select for the shared bus lines
    localparam logic OWNER_M1 = 1'b0;
    localparam logic OWNER_M2 = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles a grant has been held and flags the final allowed cycle.
module arb_watchdog #(
    parameter int unsigned TIMEOUT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam logic [TIMEOUT_LEN-1:0] LAST_COUNT = TIMEOUT_LEN'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_LEN-1:0] count;

    // Cycle counter: cleared outside grants, saturates at the last allowed cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST_COUNT);

endmodule

// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter for the shared serial bus, with grant watchdog
// and a one-cycle turnaround between owners.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       enable,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_done,
    input  logic       m2_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       bus_owner,
    output logic       timeout_err,
    output logic [1:0] arb_state
);

    arb_state_t state, state_next;
    logic       last_owner;
    logic       take_grant;
    logic       grant_to;
    logic       timeout_next;
    logic       in_grant;
    logic       wd_expire;

    assign in_grant = (state == GRANT_M1) || (state == GRANT_M2);

    arb_watchdog #(
        .TIMEOUT_LEN    (TIMEOUT_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .rst    (rst),
        .clear  (!in_grant),
        .inc    (in_grant),
        .expire (wd_expire)
    );

    // Next-state, round-robin choice and watchdog error decision.
    always_comb begin
        state_next   = state;
        take_grant   = 1'b0;
        grant_to     = OWNER_M1;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (m1_req || m2_req)) begin
                    take_grant = 1'b1;
                    if (m1_req && m2_req) begin
                        grant_to = (last_owner == OWNER_M2) ? OWNER_M1 : OWNER_M2;
                    end else begin
                        grant_to = m1_req ? OWNER_M1 : OWNER_M2;
                    end
                    state_next = (grant_to == OWNER_M1) ? GRANT_M1 : GRANT_M2;
                end
            end
            GRANT_M1: begin
                if (m1_done || !m1_req || wd_expire) begin
                    state_next   = HANDOVER;
                    timeout_next = wd_expire && !m1_done;
                end
            end
            GRANT_M2: begin
                if (m2_done || !m2_req || wd_expire) begin
                    state_next   = HANDOVER;
                    timeout_next = wd_expire && !m2_done;
                end
            end
            HANDOVER: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State, owner pointer and error pulse registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_owner  <= OWNER_M2;
            bus_owner   <= OWNER_M1;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            timeout_err <= timeout_next;
            if (take_grant) begin
                last_owner <= grant_to;
                bus_owner  <= grant_to;
            end
        end
    end

    assign m1_grant  = (state == GRANT_M1);
    assign m2_grant  = (state == GRANT_M2);
    assign arb_state = state;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_serial_bus_arbiter;

    localparam int unsigned TC = 16;

    logic       clock;
    logic       rst;
    logic       enable;
    logic       m1_req, m2_req, m1_done, m2_done;
    logic       m1_grant, m2_grant, bus_owner, timeout_err;
    logic [1:0] arb_state;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus, for how long, and remaining turnaround.
    int holder;     // 0 none, 1 master1, 2 master2
    int held;       // cycles the current grant has been visible
    int gap;        // turnaround cycles still to come before arbitration resumes
    int last;       // last master granted
    int own;        // last bus_owner value (0 = m1, 1 = m2)
    int terr;       // expected timeout_err

    serial_bus_arbiter #(
        .TIMEOUT_LEN    (8),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .m1_req      (m1_req),
        .m2_req      (m2_req),
        .m1_done     (m1_done),
        .m2_done     (m2_done),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .bus_owner   (bus_owner),
        .timeout_err (timeout_err),
        .arb_state   (arb_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        holder = 0; held = 0; gap = 0; last = 2; own = 0; terr = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int r, d, pick;
        terr = 0;
        if (holder != 0) begin
            r = (holder == 1) ? int'(m1_req) : int'(m2_req);
            d = (holder == 1) ? int'(m1_done) : int'(m2_done);
            if (d != 0 || r == 0 || held == int'(TC)) begin
                terr   = (held == int'(TC) && d == 0) ? 1 : 0;
                holder = 0;
                gap    = 1;
            end else begin
                held++;
            end
        end else if (gap > 0) begin
            gap--;
        end else if (enable && (m1_req || m2_req)) begin
            if (m1_req && m2_req) pick = (last == 1) ? 2 : 1;
            else                  pick = m1_req ? 1 : 2;
            holder = pick;
            held   = 1;
            last   = pick;
            own    = pick - 1;
        end
    endtask

    task automatic step();
        int exp_state;
        model_step();
        @(posedge clock);
        #1;
        exp_state = (holder == 1) ? 1 : (holder == 2) ? 2 : (gap > 0) ? 3 : 0;
        chk("m1_grant", m1_grant, (holder == 1) ? 1 : 0);
        chk("m2_grant", m2_grant, (holder == 2) ? 1 : 0);
        chk("bus_owner", bus_owner, own);
        chk("timeout_err", timeout_err, terr);
        chk("arb_state", arb_state, exp_state);
        chk("excl", m1_grant & m2_grant, 0);
    endtask

    task automatic do_reset();
        m1_req = 0; m2_req = 0; m1_done = 0; m2_done = 0; enable = 1;
        rst = 0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        rst = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, guard;

        // Reset values
        do_reset();
        chk("rst_m1_grant", m1_grant, 0);
        chk("rst_m2_grant", m2_grant, 0);
        chk("rst_owner", bus_owner, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_state", arb_state, 0);

        // Single m1 transaction, done after five grant cycles
        m1_req = 1;
        step();
        chk("t1_grant", m1_grant, 1);
        chk("t1_owner", bus_owner, 0);
        repeat (4) step();
        m1_done = 1;
        step();
        m1_done = 0; m1_req = 0;
        chk("t1_release", m1_grant, 0);
        chk("t1_handover", arb_state, 3);
        step();
        chk("t1_idle", arb_state, 0);

        // Tie after reset: M1 first, then strict alternation
        do_reset();
        m1_req = 1; m2_req = 1;
        step();
        chk("t2_first_m1", m1_grant, 1);
        step();
        m1_done = 1; step(); m1_done = 0;
        step(); step();
        chk("t2_m2_after3", m2_grant, 1);
        chk("t2_owner_m2", bus_owner, 1);
        m2_done = 1; step(); m2_done = 0;
        step(); step();
        chk("t2_m1_again", m1_grant, 1);
        m1_done = 1; step(); m1_done = 0; m1_req = 0; m2_req = 0;
        step();

        // Watchdog revokes a stuck m2 grant; m1 then wins the tie
        do_reset();
        m2_req = 1;
        step();
        cnt = 0; guard = 0;
        while (m2_grant && guard < 40) begin
            cnt++;
            if (cnt == 3) m1_req = 1;
            step();
            guard++;
        end
        chk("t3_grant_len", cnt, TC);
        chk("t3_terr", timeout_err, 1);
        step();
        chk("t3_terr_pulse", timeout_err, 0);
        step();
        chk("t3_tie_m1", m1_grant, 1);
        m1_req = 0; m2_req = 0;
        step(); step(); step();

        // enable low blocks grants; dropping it mid-grant keeps the grant
        enable = 0; m1_req = 1; m2_req = 1;
        repeat (10) step();
        chk("t4_no_grant", m1_grant | m2_grant, 0);
        enable = 1; m2_req = 0;
        step();
        chk("t4_grant", m1_grant, 1);
        enable = 0; m2_req = 1;
        repeat (3) step();
        chk("t4_held", m1_grant, 1);
        m1_done = 1; step(); m1_done = 0; m1_req = 0;
        repeat (5) step();
        chk("t4_still_none", m2_grant, 0);
        enable = 1;
        step();
        chk("t4_resume", m2_grant, 1);
        m2_req = 0; step(); step(); step();

        // Async reset between edges during an m1 grant
        m1_req = 1;
        step(); step();
        #2;
        rst = 0;
        #1;
        chk("t5_async_drop", m1_grant, 0);
        chk("t5_async_state", arb_state, 0);
        model_reset();
        @(posedge clock);
        #1;
        rst = 1;
        m2_req = 1;
        step();
        chk("t5_m1_first", m1_grant, 1);

        // done coincides with watchdog expiry: no error
        do_reset();
        m1_req = 1;
        step();
        repeat (TC - 1) step();
        chk("t6_last_cycle", m1_grant, 1);
        m1_done = 1;
        step();
        m1_done = 0; m1_req = 0;
        chk("t6_release", m1_grant, 0);
        chk("t6_no_terr", timeout_err, 0);
        step(); step();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if (m1_done) begin
                m1_done = 0; m1_req = 0;
            end else if (!m1_req) begin
                m1_req = ($urandom_range(0, 99) < 30);
            end else if ($urandom_range(0, 99) < 3) begin
                m1_req = 0;
            end else if ($urandom_range(0, 99) < 8) begin
                m1_done = 1;
            end
            if (m2_done) begin
                m2_done = 0; m2_req = 0;
            end else if (!m2_req) begin
                m2_req = ($urandom_range(0, 99) < 30);
            end else if ($urandom_range(0, 99) < 3) begin
                m2_req = 0;
            end else if ($urandom_range(0, 99) < 8) begin
                m2_done = 1;
            end
            enable = ($urandom_range(0, 99) < 85);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
